memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter FETCH_STARVE_LIMIT, default 4: max consecutive data grants while fetch waits.
REQ-002 SHALL have: clock  in  1  clock; reset_n  in  1  reset reset_n, asynchronous, active-low; clock clock.
REQ-003 SHALL have: f_req  in  1  fetch read request; f_address  in  32  fetch word address.
REQ-004 SHALL have: f_grant  out  1  fetch accepted; f_data_valid  out  1  fetch data strobe; f_data  out  32  instruction word.
REQ-005 SHALL have: d_req  in  1  data request; d_read  in  1  read; d_write  in  1  write; d_address  in  32; d_write_data  in  32.
REQ-006 SHALL have: d_grant  out  1  data accepted; d_done  out  1  data op complete; d_read_data  out  32  read/old value.
REQ-007 SHALL have: m_address  out  32; m_read  out  1; m_write  out  1; m_write_data  out  32; m_waitrequest  in  1; m_read_data  in  32; m_read_data_valid  in  1.

Function
REQ-008 SHALL share one memory port between fetch and data; one transaction outstanding at a time.
REQ-009 SHALL implement states IDLE, READ, READ_WAIT, WRITE; all outputs registered.
REQ-010 Data op kind: d_read only = load; d_write only = store; both = cx (atomic exchange); neither = request ignored, no grant.
REQ-011 IDLE arbitration each cycle: data wins over fetch unless starve count == FETCH_STARVE_LIMIT and f_req high, then fetch wins.
REQ-012 On acceptance edge: latch address (and d_write_data), pulse f_grant or d_grant for exactly one cycle starting next cycle, same cycle m_read/m_write rises.
REQ-013 Load/fetch/cx: enter READ, hold m_read=1 and m_address stable while m_waitrequest=1; on m_read && !m_waitrequest drop m_read next cycle, enter READ_WAIT.
REQ-014 Store: enter WRITE, hold m_write=1, m_write_data stable while m_waitrequest=1; on accept drop m_write, pulse d_done one cycle, return IDLE.
REQ-015 READ_WAIT on m_read_data_valid: fetch -> f_data_valid=1 one cycle, f_data=m_read_data; load -> d_done=1 one cycle, d_read_data=m_read_data; then IDLE.
REQ-016 cx: in READ_WAIT on valid capture old value into d_read_data, go WRITE at same address with latched d_write_data; no arbitration until write accepted; then d_done one cycle, IDLE.
REQ-017 Min latency (waitrequest=0, data valid 1 cycle after accept): grant+command at cycle 1, data/done strobe at cycle 3, next arbitration at cycle 3.
REQ-018 Starve counter: +1 per data grant while f_req=1, saturates at FETCH_STARVE_LIMIT; cleared on fetch grant or when f_req=0 in IDLE.
REQ-019 m_read_data_valid outside READ_WAIT SHALL be ignored; no strobes generated.
REQ-020 Requests arriving while not IDLE SHALL wait; requester holds req/address until grant; deasserting req before grant withdraws it.
REQ-021 f_data, d_read_data SHALL hold last value between strobes.
REQ-022 m_read and m_write SHALL never be high simultaneously.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, starve count 0, cx lock cleared, all strobe/command outputs (f_grant, f_data_valid, d_grant, d_done, m_read, m_write) 0.
REQ-024 Data outputs (f_data, d_read_data, m_address, m_write_data) SHALL reset to 0.
REQ-025 Reset mid-transaction SHALL abandon it; late m_read_data_valid after reset ignored (REQ-019).

Verification
REQ-026 Fetch only, f_address=0x100, waitrequest=0, mem returns 0xDEADBEEF one cycle later -> f_grant cycle 1, m_read cycle 1 only, f_data_valid with 0xDEADBEEF cycle 3.
REQ-027 f_req and d_req(load) both high continuously, limit 4 -> grants D,D,D,D,F,D,D,D,D,F.
REQ-028 Store 0x55 to 0x20 with m_waitrequest high 3 cycles -> m_write high 4 cycles, address/data stable, d_done one cycle after accept.
REQ-029 cx addr 0x40, d_write_data=0x7, memory old 0x3, f_req high throughout -> m_read then m_write at 0x40 with 0x7, no f_grant in between, d_read_data=0x3 with d_done.
REQ-030 Reset asserted during READ_WAIT, then valid arrives -> all outputs 0, no f_data_valid/d_done, next request served normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// Shares one memory port between an instruction fetch requester and a data requester
// (load / store / atomic exchange). One transaction is in flight at a time; every output is a register.
module memory_arbiter #(
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        f_grant,
  output logic        f_data_valid,
  output logic [31:0] f_data,
  input  logic        d_req,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  output logic        d_grant,
  output logic        d_done,
  output logic [31:0] d_read_data,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_write_data,
  input  logic        m_waitrequest,
  input  logic [31:0] m_read_data,
  input  logic        m_read_data_valid,
  output logic [1:0]  o_dbg_state
);

  localparam int SW = (FETCH_STARVE_LIMIT > 0) ? $clog2(FETCH_STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_READ_WAIT, S_WRITE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_is_fetch, w_is_fetch_nxt;
  logic          r_is_cx, w_is_cx_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic          r_f_grant, w_f_grant_nxt;
  logic          r_d_grant, w_d_grant_nxt;
  logic          r_f_data_valid, w_f_data_valid_nxt;
  logic          r_d_done, w_d_done_nxt;
  logic          r_m_read, w_m_read_nxt;
  logic          r_m_write, w_m_write_nxt;
  logic [31:0]   r_m_address, w_m_address_nxt;
  logic [31:0]   r_m_write_data, w_m_write_data_nxt;
  logic [31:0]   r_f_data, w_f_data_nxt;
  logic [31:0]   r_d_read_data, w_d_read_data_nxt;

  logic w_data_op, w_starved, w_take_f, w_take_d;
  logic w_rd_accept, w_wr_accept, w_rd_valid;

  // A data request with neither read nor write set is not a request at all.
  assign w_data_op   = d_req && (d_read || d_write);
  assign w_starved   = (r_starve == STARVE_MAX);
  assign w_take_f    = (r_state == S_IDLE) && f_req && (!w_data_op || w_starved);
  assign w_take_d    = (r_state == S_IDLE) && w_data_op && !w_take_f;
  assign w_rd_accept = (r_state == S_READ) && !m_waitrequest;
  assign w_wr_accept = (r_state == S_WRITE) && !m_waitrequest;
  assign w_rd_valid  = (r_state == S_READ_WAIT) && m_read_data_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_is_fetch     <= 1'b0;
      r_is_cx        <= 1'b0;
      r_starve       <= '0;
      r_f_grant      <= 1'b0;
      r_d_grant      <= 1'b0;
      r_f_data_valid <= 1'b0;
      r_d_done       <= 1'b0;
      r_m_read       <= 1'b0;
      r_m_write      <= 1'b0;
      r_m_address    <= '0;
      r_m_write_data <= '0;
      r_f_data       <= '0;
      r_d_read_data  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_is_fetch     <= w_is_fetch_nxt;
      r_is_cx        <= w_is_cx_nxt;
      r_starve       <= w_starve_nxt;
      r_f_grant      <= w_f_grant_nxt;
      r_d_grant      <= w_d_grant_nxt;
      r_f_data_valid <= w_f_data_valid_nxt;
      r_d_done       <= w_d_done_nxt;
      r_m_read       <= w_m_read_nxt;
      r_m_write      <= w_m_write_nxt;
      r_m_address    <= w_m_address_nxt;
      r_m_write_data <= w_m_write_data_nxt;
      r_f_data       <= w_f_data_nxt;
      r_d_read_data  <= w_d_read_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_take_f) w_state_nxt = S_READ;
        else if (w_take_d) w_state_nxt = (d_write && !d_read) ? S_WRITE : S_READ;
      end
      S_READ:      if (w_rd_accept) w_state_nxt = S_READ_WAIT;
      // An exchange keeps the port locked and goes straight on to its write.
      S_READ_WAIT: if (w_rd_valid) w_state_nxt = r_is_cx ? S_WRITE : S_IDLE;
      S_WRITE:     if (w_wr_accept) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_f_grant_nxt      = 1'b0;
    w_d_grant_nxt      = 1'b0;
    w_f_data_valid_nxt = 1'b0;
    w_d_done_nxt       = 1'b0;
    w_m_read_nxt       = r_m_read;
    w_m_write_nxt      = r_m_write;
    w_m_address_nxt    = r_m_address;
    w_m_write_data_nxt = r_m_write_data;
    w_f_data_nxt       = r_f_data;
    w_d_read_data_nxt  = r_d_read_data;
    w_is_fetch_nxt     = r_is_fetch;
    w_is_cx_nxt        = r_is_cx;
    w_starve_nxt       = r_starve;

    if (w_take_f) begin
      w_f_grant_nxt   = 1'b1;
      w_m_read_nxt    = 1'b1;
      w_m_address_nxt = f_address;
      w_is_fetch_nxt  = 1'b1;
      w_is_cx_nxt     = 1'b0;
      w_starve_nxt    = '0;
    end else if (w_take_d) begin
      w_d_grant_nxt      = 1'b1;
      w_m_read_nxt       = d_read;
      w_m_write_nxt      = d_write && !d_read;
      w_m_address_nxt    = d_address;
      w_m_write_data_nxt = d_write_data;
      w_is_fetch_nxt     = 1'b0;
      w_is_cx_nxt        = d_read && d_write;
      if (!f_req) w_starve_nxt = '0;
      else if (!w_starved) w_starve_nxt = r_starve + 1'b1;
    end else if ((r_state == S_IDLE) && !f_req) begin
      w_starve_nxt = '0;
    end

    if (w_rd_accept) w_m_read_nxt = 1'b0;

    if (w_rd_valid) begin
      if (r_is_fetch) begin
        w_f_data_valid_nxt = 1'b1;
        w_f_data_nxt       = m_read_data;
      end else begin
        w_d_read_data_nxt = m_read_data;
        if (r_is_cx) w_m_write_nxt = 1'b1;
        else         w_d_done_nxt  = 1'b1;
      end
    end

    if (w_wr_accept) begin
      w_m_write_nxt = 1'b0;
      w_d_done_nxt  = 1'b1;
      w_is_cx_nxt   = 1'b0;
    end
  end

  assign f_grant      = r_f_grant;
  assign f_data_valid = r_f_data_valid;
  assign f_data       = r_f_data;
  assign d_grant      = r_d_grant;
  assign d_done       = r_d_done;
  assign d_read_data  = r_d_read_data;
  assign m_address    = r_m_address;
  assign m_read       = r_m_read;
  assign m_write      = r_m_write;
  assign m_write_data = r_m_write_data;
  assign o_dbg_state  = r_state;

endmodule
